// File: rtl/b16fp_dot_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : b16fp_dot_seq_if
// Description : Bundle of the operand stream, MAC drive/return and result
//               stream signals used by the b16fp_dot_seq sequencer.
//               master : sequencer view (drives in_ready, mac_*, out_*, busy)
//               slave  : environment view (source, MAC and result consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface b16fp_dot_seq_if #(
    parameter int CNT_W = 16
) ();
    // operand stream
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             in_last;
    // MAC drive and return
    logic             mac_clr;
    logic             mac_valid;
    logic [15:0]      mac_oprA;
    logic [15:0]      mac_oprB;
    logic [15:0]      mac_result;
    // result stream
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        input  in_valid, in_a, in_b, in_last, mac_result, out_ready,
        output in_ready, mac_clr, mac_valid, mac_oprA, mac_oprB,
               out_valid, out_data, out_count, busy
    );

    modport slave (
        output in_valid, in_a, in_b, in_last, mac_result, out_ready,
        input  in_ready, mac_clr, mac_valid, mac_oprA, mac_oprB,
               out_valid, out_data, out_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/b16fp_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : b16fp_dot_seq
// Description : Initiator-side sequencer for a bfloat16 MAC. Takes a stream
//               of operand pairs (vector end marked by in_last), clears the
//               MAC accumulator, feeds one pair per accepted beat, waits out
//               the MAC pipeline and returns the dot product with its beat
//               count on a valid/ready output.
// Ports       : clk, rst (async, active high)
//               bus.in_*   : operand pair stream (valid/ready, last)
//               bus.mac_*  : MAC clear/valid/operands out, result in
//               bus.out_*  : dot product + saturating beat count (valid/ready)
//               bus.busy   : high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module b16fp_dot_seq #(
    parameter int MAC_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  wire             clk,
    input  wire             rst,
    b16fp_dot_seq_if.master bus
);

    localparam int c_drain_w = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(MAC_LAT);
    localparam logic [CNT_W-1:0]     c_beat_max   = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_mac_clr;
    logic                 r_mac_valid;
    logic [15:0]          r_opra;
    logic [15:0]          r_oprb;
    logic [CNT_W-1:0]     r_beat;
    logic [c_drain_w-1:0] r_drain;
    logic                 r_out_valid;
    logic [15:0]          r_out_data;
    logic [CNT_W-1:0]     r_out_count;

    state_t               w_state_nxt;
    logic                 w_mac_clr_nxt;
    logic                 w_mac_valid_nxt;
    logic [15:0]          w_opra_nxt;
    logic [15:0]          w_oprb_nxt;
    logic [CNT_W-1:0]     w_beat_nxt;
    logic [c_drain_w-1:0] w_drain_nxt;
    logic                 w_out_valid_nxt;
    logic [15:0]          w_out_data_nxt;
    logic [CNT_W-1:0]     w_out_count_nxt;
    logic                 w_accept;

    assign w_accept = bus.in_valid && (r_state == S_STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mac_clr   <= 1'b0;
            r_mac_valid <= 1'b0;
            r_opra      <= 16'h0000;
            r_oprb      <= 16'h0000;
            r_beat      <= '0;
            r_drain     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mac_clr   <= w_mac_clr_nxt;
            r_mac_valid <= w_mac_valid_nxt;
            r_opra      <= w_opra_nxt;
            r_oprb      <= w_oprb_nxt;
            r_beat      <= w_beat_nxt;
            r_drain     <= w_drain_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_count <= w_out_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mac_clr_nxt   = 1'b0;      // one-cycle pulse, only while in CLEAR
        w_mac_valid_nxt = 1'b0;      // one cycle per accepted beat
        w_opra_nxt      = r_opra;
        w_oprb_nxt      = r_oprb;
        w_beat_nxt      = r_beat;
        w_drain_nxt     = r_drain;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_count_nxt = r_out_count;

        case (r_state)
            S_IDLE: begin
                // the waiting pair is left in place and taken in STREAM
                if (bus.in_valid) begin
                    w_state_nxt   = S_CLEAR;
                    w_mac_clr_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                w_beat_nxt  = '0;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_accept) begin
                    w_opra_nxt      = bus.in_a;
                    w_oprb_nxt      = bus.in_b;
                    w_mac_valid_nxt = 1'b1;
                    if (r_beat != c_beat_max) begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                    if (bus.in_last) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = c_drain_init;
                    end
                end
            end
            S_DRAIN: begin
                // MAC_LAT+1 edges after the last beat the MAC result is final
                if (r_drain == '0) begin
                    w_out_data_nxt  = bus.mac_result;
                    w_out_count_nxt = r_beat;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_OUT;
                end else begin
                    w_drain_nxt = r_drain - 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == S_STREAM);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.mac_clr   = r_mac_clr;
    assign bus.mac_valid = r_mac_valid;
    assign bus.mac_oprA  = r_opra;
    assign bus.mac_oprB  = r_oprb;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_b16fp_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_b16fp_dot_seq
// Description : Self-checking bench for b16fp_dot_seq. A behavioural bfloat16
//               MAC (real arithmetic, MAC_LAT-deep result pipeline) answers
//               the sequencer; expected dot products are computed per vector
//               from the operand lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b16fp_dot_seq;

    localparam int MAC_LAT = 3;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    int   acc_q[$];   // cycle index of each accepting edge
    int   mv_q[$];    // cycles with mac_valid high
    int   clr_q[$];   // cycles with mac_clr high

    b16fp_dot_seq_if #(.CNT_W(16)) mif ();
    b16fp_dot_seq_if #(.CNT_W(2))  mif2 ();

    b16fp_dot_seq #(.MAC_LAT(MAC_LAT), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    b16fp_dot_seq #(.MAC_LAT(MAC_LAT), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (mif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bfloat16 <-> real (exact for the values used) ---------
    function automatic real bf2r(input logic [15:0] b);
        logic [63:0] d;
        if (b[14:7] == 8'd0) return 0.0;
        d = {b[15], 11'(int'(b[14:7]) - 127 + 1023), b[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        if (r == 0.0) return 16'h0000;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:45]};
    endfunction

    // ---------------- behavioural MAC ---------------------------------------
    real         macc;
    logic [15:0] pipe [MAC_LAT];

    always @(posedge clk or posedge rst) begin
        if (rst || mif.mac_clr) begin
            macc <= 0.0;
            for (int i = 0; i < MAC_LAT; i++) pipe[i] <= 16'h0000;
        end else begin
            if (mif.mac_valid) begin
                macc    <= macc + bf2r(mif.mac_oprA) * bf2r(mif.mac_oprB);
                pipe[0] <= r2bf(macc + bf2r(mif.mac_oprA) * bf2r(mif.mac_oprB));
            end else begin
                pipe[0] <= r2bf(macc);
            end
            for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign mif.mac_result  = pipe[MAC_LAT-1];
    assign mif2.mac_result = 16'h0000;

    always @(negedge clk) begin
        if (mif.mac_valid) mv_q.push_back(cyc);
        if (mif.mac_clr)   clr_q.push_back(cyc);
    end

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers --------------------------------------
    task automatic send_beats(input logic [15:0] av[$], input logic [15:0] bv[$],
                              input int gapmask, input bit mark_last);
        int w;
        for (int i = 0; i < av.size(); i++) begin
            if (i > 0 && gapmask[i]) begin
                mif.in_valid = 1'b0;
                @(negedge clk);
            end
            mif.in_valid = 1'b1;
            mif.in_a     = av[i];
            mif.in_b     = bv[i];
            mif.in_last  = mark_last && (i == av.size() - 1);
            w = 0;
            while (!mif.in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!mif.in_ready) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                mif.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            acc_q.push_back(cyc);
        end
        mif.in_valid = 1'b0;
        mif.in_last  = 1'b0;
    endtask

    task automatic collect(input logic [15:0] exp_data, input int exp_count,
                           input int hold);
        int k;
        logic [15:0] d0;
        k = 0;
        while (!mif.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("result_latency", k, MAC_LAT + 1);
        chk("out_data", mif.out_data, exp_data);
        chk("out_count", mif.out_count, exp_count);
        d0 = mif.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", mif.out_valid, 1);
            chk("hold_data", mif.out_data, d0);
            chk("hold_in_ready", mif.in_ready, 0);
        end
        mif.out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", mif.out_valid, 0);
        chk("idle_busy", mif.busy, 0);
    endtask

    task automatic run_vec(input logic [15:0] av[$], input logic [15:0] bv[$],
                           input int gapmask, input int hold);
        real s;
        acc_q.delete();
        mv_q.delete();
        clr_q.delete();
        mif.out_ready = (hold == 0);
        s = 0.0;
        for (int i = 0; i < av.size(); i++) s = s + bf2r(av[i]) * bf2r(bv[i]);
        send_beats(av, bv, gapmask, 1'b1);
        collect(r2bf(s), av.size(), hold);
        chk("mac_valid_beats", mv_q.size(), acc_q.size());
        for (int i = 0; i < acc_q.size() && i < mv_q.size(); i++)
            chk("mac_valid_cycle", mv_q[i], acc_q[i]);
        chk("clr_pulses", clr_q.size(), 1);
        if (clr_q.size() > 0 && mv_q.size() > 0)
            chk("clr_before_valid", clr_q[0] < mv_q[0], 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},  mif.in_ready, 0);
        chk({tag, "_busy"},      mif.busy, 0);
        chk({tag, "_mac_clr"},   mif.mac_clr, 0);
        chk({tag, "_mac_valid"}, mif.mac_valid, 0);
        chk({tag, "_opra"},      mif.mac_oprA, 0);
        chk({tag, "_oprb"},      mif.mac_oprB, 0);
        chk({tag, "_out_valid"}, mif.out_valid, 0);
        chk({tag, "_out_data"},  mif.out_data, 0);
        chk({tag, "_out_count"}, mif.out_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] av[$];
        logic [15:0] bv[$];
        int n;
        int k;
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        mif.in_valid  = 1'b0;
        mif.in_a      = 16'h0;
        mif.in_b      = 16'h0;
        mif.in_last   = 1'b0;
        mif.out_ready = 1'b1;
        mif2.in_valid  = 1'b0;
        mif2.in_a      = 16'h0;
        mif2.in_b      = 16'h0;
        mif2.in_last   = 1'b0;
        mif2.out_ready = 1'b1;

        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // single beat 1.0*1.0
        av = {16'h3F80}; bv = {16'h3F80};
        run_vec(av, bv, 0, 0);

        // two beats 2*3 + 1*1 = 7
        av = {16'h4000, 16'h3F80}; bv = {16'h4040, 16'h3F80};
        run_vec(av, bv, 0, 0);

        // back-to-back: 4.0 then 2.0 (second must not carry the first)
        av = {16'h4000}; bv = {16'h4000};
        run_vec(av, bv, 0, 0);
        av = {16'h3F80}; bv = {16'h4000};
        run_vec(av, bv, 0, 0);

        // gap before the third beat, output held off for 5 cycles -> 3.0
        av = {16'h3F80, 16'h3F80, 16'h3F80}; bv = {16'h3F80, 16'h3F80, 16'h3F80};
        run_vec(av, bv, 32'b100, 5);

        // reset after 2 of 4 beats, then resend a single-beat vector
        acc_q.delete();
        av = {16'h3F80, 16'h4000}; bv = {16'h3F80, 16'h4000};
        send_beats(av, bv, 0, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        av = {16'h3F80}; bv = {16'h4000};
        run_vec(av, bv, 0, 0);

        // randomized vectors of small integers (exact in bfloat16)
        for (int t = 0; t < 20; t++) begin
            av.delete();
            bv.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                av.push_back(r2bf(real'($urandom_range(0, 8)) - 4.0));
                bv.push_back(r2bf(real'($urandom_range(0, 8)) - 4.0));
            end
            run_vec(av, bv, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        // beat counter saturation on a 2-bit counter: 5 beats -> 3
        mif2.in_valid = 1'b1;
        k = 0;
        while (!mif2.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sat_in_ready", mif2.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            mif2.in_last = (i == 4);
            @(negedge clk);
        end
        mif2.in_valid = 1'b0;
        mif2.in_last  = 1'b0;
        k = 0;
        while (!mif2.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("sat_latency", k, MAC_LAT + 1);
        chk("sat_out_count", mif2.out_count, 3);
        chk("sat_out_data", mif2.out_data, 16'h0000);
        @(negedge clk);
        chk("sat_idle", mif2.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
